// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
// The arbiter takes the slave view; the requesters and the memory take the master view.
interface rom_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_addr,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_addr,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Two-port arbiter for a single-port, one-cycle-latency instruction memory.
// Fetch has priority; a starvation counter forces a loader grant.
module rom_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rstn,
  rom_port_arbiter_if.slave bus
);

  localparam logic [7:0] LP_MAX = 8'(STARVE_MAX);

  logic [7:0]        r_starve;
  logic              r_pend;
  logic              r_owner;
  logic              r_we;
  logic [DATA_W-1:0] r_hold0;
  logic [DATA_W-1:0] r_hold1;

  logic              w_force;
  logic              w_pick0;
  logic              w_pick1;
  logic              w_g0;
  logic              w_g1;
  logic              w_en;
  logic              w_rv0;
  logic              w_rv1;
  logic [DATA_W-1:0] w_d1;

  // Loader wins when starved, otherwise only when fetch is idle.
  assign w_force = bus.m1_req && (r_starve == LP_MAX);
  assign w_pick0 = rstn && bus.m0_req && !w_force;
  assign w_pick1 = rstn && (w_force
                 || (bus.m1_req && !bus.m0_req));

  // One-hot grant decode; no grant while reset is held.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    unique case (1'b1)
      w_pick0: w_g0 = 1'b1;
      w_pick1: w_g1 = 1'b1;
      default: ;
    endcase
  end

  assign w_en = w_g0 | w_g1;

  assign bus.m0_gnt    = w_g0;
  assign bus.m1_gnt    = w_g1;
  assign bus.mem_en    = w_en;
  assign bus.mem_we    = w_g1 & bus.m1_we;
  assign bus.mem_addr  = w_g1 ? bus.m1_addr
                              : bus.m0_addr;
  assign bus.mem_wdata = w_g1 ? bus.m1_wdata
                              : '0;

  // Count consecutive loader losses, saturating at the threshold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_starve <= '0;
    end else if (!bus.m1_req || w_g1) begin
      r_starve <= '0;
    end else if (r_starve != LP_MAX) begin
      r_starve <= r_starve + 8'd1;
    end
  end

  // Remember who owns the data returning next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend  <= 1'b0;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_pend  <= w_en;
      r_owner <= w_g1;
      r_we    <= w_g1 & bus.m1_we;
    end
  end

  assign w_rv0 = r_pend & ~r_owner;
  assign w_rv1 = r_pend & r_owner;
  assign w_d1  = r_we ? '0 : bus.mem_rdata;

  // Keep the last delivered word visible between responses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold0 <= '0;
      r_hold1 <= '0;
    end else begin
      if (w_rv0) r_hold0 <= bus.mem_rdata;
      if (w_rv1) r_hold1 <= w_d1;
    end
  end

  assign bus.m0_rvalid = w_rv0;
  assign bus.m1_rvalid = w_rv1;
  assign bus.m0_rdata  = w_rv0 ? bus.mem_rdata
                               : r_hold0;
  assign bus.m1_rdata  = w_rv1 ? w_d1 : r_hold1;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a small
// write-first synchronous memory model.
module tb_rom_port_arbiter;

  logic clk;
  logic rstn;
  int   n_vec;
  int   n_bad;

  rom_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rom_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_MAX(8)
  ) u_dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] romw(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  logic [31:0]  wmem [0:255];
  logic [255:0] wval;
  logic [7:0]   midx;
  assign midx = bus.mem_addr[9:2];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wval <= '0;
    end else if (bus.mem_en && bus.mem_we) begin
      wmem[midx] <= bus.mem_wdata;
      wval[midx] <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= wval[midx] ? wmem[midx]
                                  : romw(bus.mem_addr);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.m0_req   = 1'b0;
    bus.m0_addr  = '0;
    bus.m1_req   = 1'b0;
    bus.m1_we    = 1'b0;
    bus.m1_addr  = '0;
    bus.m1_wdata = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    idle();
    rstn = 1'b0;
    bus.m0_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rv0", bus.m0_rvalid, 0);
    chk("rst_rv1", bus.m1_rvalid, 0);
    chk("rst_rd0", bus.m0_rdata, 0);
    chk("rst_rd1", bus.m1_rdata, 0);
    chk("rst_gnt0", bus.m0_gnt, 0);
    nxt();
    rstn = 1'b1;

    // fetch streaming
    for (int k = 0; k < 8; k++) begin
      bus.m0_addr = 32'(4 * k);
      @(negedge clk);
      chk("st_gnt0", bus.m0_gnt, 1);
      chk("st_gnt1", bus.m1_gnt, 0);
      chk("st_addr", bus.mem_addr, 32'(4 * k));
      chk("st_rv1", bus.m1_rvalid, 0);
      if (k > 0) begin
        chk("st_rv0", bus.m0_rvalid, 1);
        chk("st_rd0", bus.m0_rdata, romw(32'(4 * (k - 1))));
      end else begin
        chk("st_rv0_first", bus.m0_rvalid, 0);
      end
      nxt();
    end
    bus.m0_req = 1'b0;
    @(negedge clk);
    chk("st_last_rv0", bus.m0_rvalid, 1);
    chk("st_last_rd0", bus.m0_rdata, romw(32'd28));
    chk("idle_gnt0", bus.m0_gnt, 0);
    chk("idle_en", bus.mem_en, 0);
    nxt();
    @(negedge clk);
    chk("hold_rv0", bus.m0_rvalid, 0);
    chk("hold_rd0", bus.m0_rdata, romw(32'd28));
    nxt();

    // loader write then read
    bus.m1_req   = 1'b1;
    bus.m1_we    = 1'b1;
    bus.m1_addr  = 32'h40;
    bus.m1_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_gnt1", bus.m1_gnt, 1);
    chk("wr_we", bus.mem_we, 1);
    chk("wr_wdata", bus.mem_wdata, 32'hDEADBEEF);
    nxt();
    bus.m1_we = 1'b0;
    @(negedge clk);
    chk("wr_ack_rv1", bus.m1_rvalid, 1);
    chk("wr_ack_rd1", bus.m1_rdata, 0);
    chk("rd_gnt1", bus.m1_gnt, 1);
    chk("rd_we", bus.mem_we, 0);
    nxt();
    bus.m1_req = 1'b0;
    @(negedge clk);
    chk("rd_rv1", bus.m1_rvalid, 1);
    chk("rd_rd1", bus.m1_rdata, 32'hDEADBEEF);
    chk("rd_rv0", bus.m0_rvalid, 0);
    nxt();

    // starvation guard
    bus.m0_req  = 1'b1;
    bus.m0_addr = 32'h8;
    bus.m1_req  = 1'b1;
    bus.m1_addr = 32'h44;
    for (int i = 0; i < 27; i++) begin
      logic e1;
      e1 = (i % 9) == 8;
      @(negedge clk);
      chk("sv_gnt0", bus.m0_gnt, !e1);
      chk("sv_gnt1", bus.m1_gnt, e1);
      chk("sv_addr", bus.mem_addr, e1 ? 32'h44 : 32'h8);
      nxt();
    end
    idle();
    nxt();
    nxt();

    // alternating contention
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        bus.m0_req  = 1'b1;
        bus.m1_req  = 1'b0;
        bus.m0_addr = 32'h100 + 32'(4 * i);
      end else begin
        bus.m0_req  = 1'b0;
        bus.m1_req  = 1'b1;
        bus.m1_addr = 32'h200 + 32'(4 * i);
      end
      @(negedge clk);
      chk("ct_gnt0", bus.m0_gnt, (i % 2) == 0);
      chk("ct_gnt1", bus.m1_gnt, (i % 2) == 1);
      if (i > 0) begin
        if ((i - 1) % 2 == 1) begin
          chk("ct_rv1", bus.m1_rvalid, 1);
          chk("ct_rv0n", bus.m0_rvalid, 0);
          chk("ct_rd1", bus.m1_rdata,
              romw(32'h200 + 32'(4 * (i - 1))));
        end else begin
          chk("ct_rv0", bus.m0_rvalid, 1);
          chk("ct_rv1n", bus.m1_rvalid, 0);
          chk("ct_rd0", bus.m0_rdata,
              romw(32'h100 + 32'(4 * (i - 1))));
        end
      end
      nxt();
    end
    idle();
    @(negedge clk);
    chk("ct_end_rv1", bus.m1_rvalid, 1);
    chk("ct_end_rd1", bus.m1_rdata, romw(32'h21C));
    nxt();
    nxt();

    // reset mid-operation, counter part-way up
    bus.m0_req  = 1'b1;
    bus.m1_req  = 1'b1;
    bus.m0_addr = 32'h0;
    bus.m1_addr = 32'h44;
    repeat (5) nxt();
    rstn = 1'b0;
    @(negedge clk);
    chk("mr_rv0", bus.m0_rvalid, 0);
    chk("mr_rv1", bus.m1_rvalid, 0);
    chk("mr_gnt0", bus.m0_gnt, 0);
    nxt();
    rstn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("mr_post_rv0", bus.m0_rvalid, 0);
        chk("mr_post_rv1", bus.m1_rvalid, 0);
      end
      chk("mr_gnt0_seq", bus.m0_gnt, i != 8);
      chk("mr_gnt1_seq", bus.m1_gnt, i == 8);
      nxt();
    end
    idle();
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares one single-port, synchronous-read instruction memory between two requesters.
  - Port 0: the core fetch path, high priority.
  - Port 1: a debug/loader path that can read and write.
- Sits between riscv and the instruction memory in riscv_soc.
  - The memory has one-cycle read latency.
  - Fixed priority goes to fetch, with a starvation guard that guarantees loader progress.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- STARVE_MAX, 8, consecutive lost cycles after which port 1 is forced a grant; range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- m0_req  input  1  fetch request, level.
- m0_addr  input  ADDR_W  fetch byte address.
- m0_gnt  output  1  fetch request accepted this cycle.
- m0_rvalid  output  1  fetch read data valid.
- m0_rdata  output  DATA_W  fetch read data.
- m1_req  input  1  loader request, level.
- m1_we  input  1  loader write enable, 1 = write.
- m1_addr  input  ADDR_W  loader byte address.
- m1_wdata  input  DATA_W  loader write data.
- m1_gnt  output  1  loader request accepted this cycle.
- m1_rvalid  output  1  loader response: read data valid, or write acknowledge.
- m1_rdata  output  DATA_W  loader read data; 0 on a write acknowledge.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address, passed through from the winning port.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0.

Behaviour:
- Reset (rstn=0, asynchronous): the following clear to 0 immediately:
  - m0_rvalid, m1_rvalid, m0_rdata, m1_rdata
  - starve counter
  - resp_owner, resp_pend
- Grant logic is combinational in the request cycle. Exactly one of m0_gnt/m1_gnt is 1, or neither.
- Arbitration in cycle t:
  - If m1_req=1 and starve_cnt == STARVE_MAX: m1 wins.
  - Else if m0_req=1: m0 wins.
  - Else if m1_req=1: m1 wins.
  - Else: idle, mem_en=0.
- Memory drive:
  - mem_en = m0_gnt | m1_gnt.
  - mem_we = m1_gnt & m1_we; mem_we is never 1 for port 0.
  - mem_addr/mem_wdata come from the winner.
  - With no grant, mem_addr/mem_wdata hold m0 values and mem_we=0.
- Starve counter:
  - Increments when m1_req=1 and m1_gnt=0.
  - Saturates at STARVE_MAX.
  - Clears to 0 on m1_gnt or when m1_req=0.
- Response pipeline: registers resp_pend = mem_en and resp_owner = m1_gnt at the clock edge. In cycle t+1:
  - If resp_pend and owner=0: m0_rvalid=1, m0_rdata=mem_rdata.
  - If resp_pend and owner=1 and the access was a read: m1_rvalid=1, m1_rdata=mem_rdata.
  - If resp_pend and owner=1 and the access was a write: m1_rvalid=1, m1_rdata=0.
  - rvalid pulses for one cycle.
  - rdata holds its last value while rvalid=0, except reset.
- Pipelining: a new grant may be issued every cycle (back-to-back, full throughput). The response for access k and the grant for access k+1 coincide.
- Requester contract:
  - Hold req/addr/we/wdata stable until gnt is seen.
  - Deasserting req without gnt is allowed; that request is dropped with no side effect.
- Simultaneous m0_req and m1_req below the starvation threshold: m0 wins and the m1 counter increments.
- At threshold: m1 wins for exactly one cycle, then the counter restarts at 0.
  - Worst-case m1 wait is STARVE_MAX+1 cycles.
- Write-then-read to the same address on consecutive cycles: the read returns the new data, because the memory is write-first at the edge.
- Reset mid-operation: any pending response is discarded, and no rvalid is emitted after rstn rises.
- Grants are combinational from req and the counter. There is no combinational path from mem_rdata to any grant.

Test Plan:
- Reset with m0_req=1: all rvalid/rdata=0 during reset. First m0_gnt appears in the cycle after release; m0_rvalid follows one cycle later with the ROM word at 0x00000000.
- Fetch streaming: m0_req held high, addr 0x0,0x4,0x8,... -> m0_gnt=1 every cycle; m0_rvalid continuous from cycle 2 with matching words; m1 idle throughout.
- Loader alone:
  - Write 0xDEADBEEF at 0x40: m1_gnt with mem_we=1, then m1_rvalid with rdata=0.
  - Read 0x40 next cycle: m1_rvalid with 0xDEADBEEF.
- Starvation with STARVE_MAX=8: m0_req and m1_req held high -> m0 wins 8 cycles, m1_gnt on the 9th, then m0 for 8 more, repeating; no cycle has both grants.
- Contention ordering: m0 and m1 reads granted in alternating cycles -> each rvalid is routed to the correct port with correct data; the other port's rvalid=0.
- Reset asserted the cycle after a grant -> rvalid stays 0; the counter restarts at 0 after release.
